// File: rtl/count_share_pkg.sv
// Shared types and constants for the event-counter sharing controller.
package count_share_pkg;
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, REPORT} state_t;
    localparam int          ID_W        = 3;
    localparam logic [15:0] TIMEOUT_DEF = 16'hFFF0;
endpackage

// File: rtl/count_share_ctrl_rr_pick.sv
// Combinational round-robin selector: lowest set req at or above ptr, with wrap.
module count_share_ctrl_rr_pick
    import count_share_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [ID_W-1:0]  idx,
    output logic             any
);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;

    // Rotate so bit 0 of rot is the requester at ptr.
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[N_REQ-1:0];

    always_comb begin
        int s;
        s   = 0;
        any = 1'b0;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                s = int'(ptr) + i;
                if (s >= N_REQ) s = s - N_REQ;
                any = 1'b1;
                idx = ID_W'(s);
            end
        end
    end

    assign onehot = any ? (N_REQ'(1) << idx) : '0;
endmodule

// File: rtl/count_share_ctrl.sv
// Time-shares one enable-gated event counter among N_REQ requesters, round-robin.
module count_share_ctrl
    import count_share_pkg::*;
#(
    parameter int               N_REQ   = 4,
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] stop,
    output logic [N_REQ-1:0] grant,
    output logic             cnt_rst,
    output logic             cnt_en,
    input  logic [CNT_W-1:0] cnt_value,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ID_W-1:0]  res_id,
    output logic [CNT_W-1:0] res_count,
    output logic             res_timeout
);
    state_t           state;
    logic [ID_W-1:0]  ptr, own, nxt_ptr;
    logic [N_REQ-1:0] pick_oh;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;
    logic             own_stop, own_req;

    count_share_ctrl_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // grant is one-hot on the owner, so masking with it selects the owner's bit.
    assign own_stop = |(stop & grant);
    assign own_req  = |(req & grant);
    assign nxt_ptr  = (own == ID_W'(N_REQ - 1)) ? '0 : own + ID_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            own         <= '0;
            grant       <= '0;
            cnt_rst     <= 1'b0;
            cnt_en      <= 1'b0;
            res_valid   <= 1'b0;
            res_id      <= '0;
            res_count   <= '0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pick_any) begin
                    grant   <= pick_oh;
                    own     <= pick_idx;
                    cnt_rst <= 1'b1;
                    state   <= CLEAR;
                end
                CLEAR: begin
                    cnt_rst <= 1'b0;
                    cnt_en  <= 1'b1;
                    state   <= RUN;
                end
                RUN: begin
                    if (own_stop || cnt_value == TIMEOUT) begin
                        res_count   <= own_stop ? cnt_value : TIMEOUT;
                        res_timeout <= !own_stop;
                        res_valid   <= 1'b1;
                        res_id      <= own;
                        cnt_en      <= 1'b0;
                        state       <= REPORT;
                    end else if (!own_req) begin
                        grant  <= '0;
                        cnt_en <= 1'b0;
                        ptr    <= nxt_ptr;
                        state  <= IDLE;
                    end
                end
                REPORT: if (res_ready) begin
                    res_valid <= 1'b0;
                    grant     <= '0;
                    ptr       <= nxt_ptr;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_count_share_ctrl.sv
// Directed bench for count_share_ctrl with a behavioural enable-gated counter.
module tb_count_share_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, stop, grant;
    logic        cnt_rst, cnt_en, res_valid, res_ready, res_timeout;
    logic [2:0]  res_id;
    logic [15:0] cnt_value, res_count;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    count_share_ctrl #(.N_REQ(4), .CNT_W(16), .TIMEOUT(16'h0010)) dut (
        .clk(clk), .rst(rst), .req(req), .stop(stop), .grant(grant),
        .cnt_rst(cnt_rst), .cnt_en(cnt_en), .cnt_value(cnt_value),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_count(res_count), .res_timeout(res_timeout)
    );

    // Shared counter: clears when reset or disabled, counts while enabled.
    always @(posedge clk) begin
        if (cnt_rst || !cnt_en) cnt_value <= 16'd0;
        else                    cnt_value <= cnt_value + 16'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        int          stop_at;   // RUN cycle carrying the owner's stop, 0 = never
        logic [3:0]  stray;     // non-owner stop bits pulsed every RUN cycle
        int          hold;      // cycles res_ready stays low in REPORT
        logic [3:0]  exp_grant;
        logic [2:0]  exp_id;
        logic [15:0] exp_count;
        logic        exp_to;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[8];

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (grant != 4'd0) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit ok, stable;
        int k;
        req = v.req;
        wait_grant(ok);
        chk("grant_seen", 32'(ok), 32'd1);
        chk("grant", 32'(grant), 32'(v.exp_grant));
        chk("clear_phase", {30'd0, cnt_rst, cnt_en}, 32'b10);
        tick();
        k = 1;
        forever begin
            stop = ((k == v.stop_at) ? v.exp_grant : 4'd0) | v.stray;
            tick();
            stop = 4'd0;
            if (res_valid) break;
            k++;
            if (k > 100) break;
        end
        chk("run_cycles", 32'(k), 32'(v.exp_cycles));
        chk("res_fields", {res_id, res_timeout, res_count},
            {v.exp_id, v.exp_to, v.exp_count});
        stable = 1'b1;
        for (int h = 0; h < v.hold; h++) begin
            tick();
            if (res_valid !== 1'b1 || res_count !== v.exp_count || res_id !== v.exp_id ||
                res_timeout !== v.exp_to || grant !== v.exp_grant || cnt_en !== 1'b0)
                stable = 1'b0;
        end
        if (v.hold > 0) chk("report_stable", 32'(stable), 32'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("after_accept", {27'd0, res_valid, grant}, 32'd0);
    endtask

    initial begin
        bit ok;
        vecs[0] = '{4'b1111, 1,  4'b0000, 0,  4'b0001, 3'd0, 16'd0,  1'b0, 1};
        vecs[1] = '{4'b1111, 1,  4'b0000, 0,  4'b0010, 3'd1, 16'd0,  1'b0, 1};
        vecs[2] = '{4'b1111, 1,  4'b0000, 0,  4'b0100, 3'd2, 16'd0,  1'b0, 1};
        vecs[3] = '{4'b1111, 1,  4'b0000, 0,  4'b1000, 3'd3, 16'd0,  1'b0, 1};
        vecs[4] = '{4'b1111, 1,  4'b0000, 0,  4'b0001, 3'd0, 16'd0,  1'b0, 1};
        vecs[5] = '{4'b0010, 6,  4'b0000, 10, 4'b0010, 3'd1, 16'd5,  1'b0, 6};
        vecs[6] = '{4'b0001, 0,  4'b0100, 2,  4'b0001, 3'd0, 16'd16, 1'b1, 17};
        vecs[7] = '{4'b0001, 17, 4'b0000, 0,  4'b0001, 3'd0, 16'd16, 1'b0, 17};

        rst = 1'b1; req = 4'd0; stop = 4'd0; res_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_outs", {grant, cnt_rst, cnt_en, res_valid, res_id, res_timeout, res_count},
            32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Abort: owner 1 drops req mid-RUN; pointer moves past it.
        req = 4'b0110;
        wait_grant(ok);
        chk("abort_grant", 32'(grant), 32'b0010);
        tick(); tick(); tick();
        req = 4'b1101;
        tick();
        chk("abort_idle", {26'd0, grant, res_valid, cnt_en}, 32'd0);
        tick();
        chk("abort_next", 32'(grant), 32'b0100);
        chk("abort_no_res", 32'(res_valid), 32'd0);
        tick();
        stop = 4'b0100;
        tick();
        stop = 4'd0;
        chk("abort_next_res", {res_valid, res_id, res_count}, {1'b1, 3'd2, 16'd0});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Reset while running clears outputs and the pointer.
        req = 4'b1111;
        wait_grant(ok);
        chk("pre_rst_grant", 32'(grant), 32'b1000);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_run_outs", {grant, cnt_rst, cnt_en, res_valid, res_id, res_timeout, res_count},
            32'd0);
        tick();
        chk("rst_cnt_cleared", 32'(cnt_value), 32'd0);
        chk("rst_ptr_zero", 32'(grant), 32'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/count_share_ctrl.md
Name: count_share_ctrl

Overview:
Controller that time-shares one 16-bit enable-gated event counter (clears whenever its enable is low, increments while high) among N_REQ requesters. It arbitrates round-robin, clears and runs the counter for the granted requester until that requester's stop strobe or a timeout, then returns the captured count over a valid/ready result port. It sits between the measurement clients and the shared counter instance, which it drives directly.

Parameters:
N_REQ, 4, number of requesters (2..8)
CNT_W, 16, counter/result width
TIMEOUT, 16'hFFF0, count value that terminates a run (must be < 2^CNT_W - 1 so the counter never wraps)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req  in  N_REQ  level request, held by requester until its result is accepted
stop  in  N_REQ  one-cycle stop strobe per requester
grant  out  N_REQ  one-hot owner of counter, 0 when idle
cnt_rst  out  1  counter reset drive
cnt_en  out  1  counter enable drive
cnt_value  in  CNT_W  counter output
res_valid  out  1  result available
res_ready  in  1  result accepted
res_id  out  3  index of requester owning result
res_count  out  CNT_W  captured count
res_timeout  out  1  run ended by TIMEOUT, not stop

Behaviour:
- Reset (rst high at clk edge): state IDLE; grant=0, cnt_rst=0, cnt_en=0, res_valid=0, res_id=0, res_count=0, res_timeout=0; rr pointer=0. All outputs registered.
- IDLE: if any req bit set, pick first set bit searching from rr pointer upward with wrap; grant<=onehot(winner); -> CLEAR. Else stay.
- CLEAR (1 cycle): cnt_rst=1, cnt_en=0; -> RUN. stop ignored here.
- RUN: cnt_en=1, cnt_rst=0. Counter reads 0 in first RUN cycle, k in (k+1)th.
  - stop[owner]=1: res_count<=cnt_value, res_timeout<=0; -> REPORT.
  - else cnt_value==TIMEOUT: res_count<=TIMEOUT, res_timeout<=1; -> REPORT.
  - stop and TIMEOUT same cycle: stop wins, res_timeout=0.
  - req[owner] drops: abort; grant<=0, cnt_en<=0, no result; rr pointer<=owner+1; -> IDLE.
  - stop of non-owner: ignored.
- REPORT: cnt_en=0; grant held; res_valid=1, res_id=owner; res_* stable until res_valid&&res_ready. On accept: res_valid<=0, grant<=0, rr pointer<=owner+1 (mod N_REQ); -> IDLE. Next grant no earlier than the cycle after accept.
- req dropping in REPORT does not cancel the result.
- rst mid-operation: immediate return to reset values; counter cleared via cnt_en=0.
- Arbitration fairness: with all req held, grants cycle 0,1,2,..,N_REQ-1,0.

Decomposition:
- Package count_share_pkg: state enum {IDLE, CLEAR, RUN, REPORT}, ID_W = 3, default TIMEOUT constant.
- Sub-module rr_pick: combinational round-robin selector (req, pointer -> one-hot winner, index, any).

Test Plan:
- req=4'b0010, stop[1] pulsed in 6th RUN cycle -> grant=4'b0010, res_id=1, res_count=5, res_timeout=0, res_valid until ready.
- req=4'b1111 held, immediate stops, res_ready=1 -> grant order 0,1,2,3,0; rr pointer wraps.
- req=4'b0001, no stop, TIMEOUT=16'h0010 -> res_count=16, res_timeout=1 after 17 RUN cycles.
- stop[owner] same cycle cnt_value==TIMEOUT -> res_timeout=0, res_count=TIMEOUT; stop[2] during owner 0's run -> ignored.
- res_ready low 10 cycles in REPORT -> res_* stable, no new grant; req[1] dropped mid-RUN -> abort, no res_valid, next grant to 2.
- rst asserted in RUN -> next cycle all outputs 0, state IDLE, rr pointer 0.
